// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - memory-mapped GPIO block with synchronized inputs and edge interrupts
module gpio_irq_ctrl #(
   parameter int         SYNC_STAGES   = 2,
   parameter logic [7:0] RESET_OUT_EN  = 8'h00,
   parameter logic [7:0] RESET_OUT_VAL = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_addr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   input  logic [7:0]  gpio_ui_in,
   output logic [7:0]  gpio_uo_out,
   output logic [7:0]  gpio_uo_en,
   output logic        irq
);

   localparam logic [2:0] A_OUT_EN  = 3'd0;
   localparam logic [2:0] A_OUT_VAL = 3'd1;
   localparam logic [2:0] A_OUT_SET = 3'd2;
   localparam logic [2:0] A_OUT_CLR = 3'd3;
   localparam logic [2:0] A_IN      = 3'd4;
   localparam logic [2:0] A_RISE_EN = 3'd5;
   localparam logic [2:0] A_FALL_EN = 3'd6;
   localparam logic [2:0] A_PEND    = 3'd7;

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] s_in;
   logic [7:0] prev_in;
   logic [7:0] out_en;
   logic [7:0] out_val;
   logic [7:0] rise_en;
   logic [7:0] fall_en;
   logic [7:0] irq_pend;
   logic [7:0] rise;
   logic [7:0] fall;
   logic [7:0] w1c_mask;
   logic [7:0] rd_mux;
   logic [2:0] word;
   logic       access;
   logic       wr;
   logic       unused_ok;

   // Bits of the bus that carry nothing for an 8-bit register file.
   assign unused_ok = &{1'b0, mem_addr[1:0], mem_wstrb[3:1], mem_wdata[31:8]};

   assign word   = mem_addr[4:2];
   assign access = mem_valid & ~mem_ready;
   assign wr     = access & mem_wstrb[0];
   assign s_in   = sync_q[SYNC_STAGES-1];

   // Input synchronizer chain plus one extra delay for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
         prev_in <= 8'h00;
      end else begin
         sync_q[0] <= gpio_ui_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_in <= s_in;
      end
   end

   // Edge qualification and the write-one-to-clear mask for this cycle.
   always_comb begin
      rise     = s_in & ~prev_in & rise_en;
      fall     = ~s_in & prev_in & fall_en;
      w1c_mask = 8'h00;
      if (wr && (word == A_PEND)) w1c_mask = mem_wdata[7:0];
   end

   // Read mux; write-only registers return zero.
   always_comb begin
      rd_mux = 8'h00;
      case (word)
         A_OUT_EN:  rd_mux = out_en;
         A_OUT_VAL: rd_mux = out_val;
         A_IN:      rd_mux = s_in;
         A_RISE_EN: rd_mux = rise_en;
         A_FALL_EN: rd_mux = fall_en;
         A_PEND:    rd_mux = irq_pend;
         default:   rd_mux = 8'h00;
      endcase
   end

   // Control registers written from the bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_en  <= RESET_OUT_EN;
         out_val <= RESET_OUT_VAL;
         rise_en <= 8'h00;
         fall_en <= 8'h00;
      end else if (wr) begin
         case (word)
            A_OUT_EN:  out_en  <= mem_wdata[7:0];
            A_OUT_VAL: out_val <= mem_wdata[7:0];
            A_OUT_SET: out_val <= out_val | mem_wdata[7:0];
            A_OUT_CLR: out_val <= out_val & ~mem_wdata[7:0];
            A_RISE_EN: rise_en <= mem_wdata[7:0];
            A_FALL_EN: fall_en <= mem_wdata[7:0];
            default:   ;
         endcase
      end
   end

   // Pending bits: a new edge wins over a clear landing on the same edge.
   always_ff @(posedge clk) begin
      if (reset) irq_pend <= 8'h00;
      else       irq_pend <= (irq_pend & ~w1c_mask) | rise | fall;
   end

   // Single-cycle ready pulse with registered read data, zero when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0;
      end else if (access) begin
         mem_ready <= 1'b1;
         mem_rdata <= {24'h0, rd_mux};
      end else begin
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0;
      end
   end

   assign gpio_uo_out = out_val;
   assign gpio_uo_en  = out_en;
   assign irq         = |irq_pend;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - self-checking bench for gpio_irq_ctrl
module tb_gpio_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [7:0]  gpio_ui_in;
   logic [7:0]  gpio_uo_out;
   logic [7:0]  gpio_uo_en;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb [$];

   typedef struct {
      logic [4:0]  addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [7:0]  out;
      logic [7:0]  en;
   } vec_t;

   vec_t vq [$];

   gpio_irq_ctrl #(.SYNC_STAGES(2), .RESET_OUT_EN(8'h00), .RESET_OUT_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .gpio_ui_in(gpio_ui_in), .gpio_uo_out(gpio_uo_out),
      .gpio_uo_en(gpio_uo_en), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic access(input logic [4:0] a, input logic [3:0] st, input logic [31:0] d,
                         input logic [31:0] exp, input string nm);
      int n;
      logic [31:0] e;
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wstrb = st;
      mem_wdata = d;
      if (st == 4'h0) sb.push_back(exp);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!mem_ready && n < 8);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      check({nm, "_latency"}, n, 1);
      if (st == 4'h0) begin
         e = sb.pop_front();
         check({nm, "_rdata"}, mem_rdata, e);
      end
      @(posedge clk);
      #1;
      check({nm, "_ready_low"}, {31'h0, mem_ready}, 32'h0);
   endtask

   initial begin
      reset      = 1'b1;
      mem_valid  = 1'b0;
      mem_addr   = 5'h0;
      mem_wstrb  = 4'h0;
      mem_wdata  = 32'h0;
      gpio_ui_in = 8'h5A;

      vq.push_back('{5'h00, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h04, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h08, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h0C, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h10, 4'h0, 32'h0,        32'h5A, 8'h00, 8'h00});
      vq.push_back('{5'h14, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h18, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h1C, 4'h0, 32'h0,        32'h00, 8'h00, 8'h00});
      vq.push_back('{5'h04, 4'h1, 32'hA5,       32'h00, 8'hA5, 8'h00});
      vq.push_back('{5'h08, 4'h1, 32'h0A,       32'h00, 8'hAF, 8'h00});
      vq.push_back('{5'h0C, 4'h1, 32'h81,       32'h00, 8'h2E, 8'h00});
      vq.push_back('{5'h04, 4'h2, 32'hFF,       32'h00, 8'h2E, 8'h00});
      vq.push_back('{5'h04, 4'h0, 32'h0,        32'h2E, 8'h2E, 8'h00});
      vq.push_back('{5'h00, 4'h1, 32'h3C,       32'h00, 8'h2E, 8'h3C});
      vq.push_back('{5'h00, 4'h0, 32'h0,        32'h3C, 8'h2E, 8'h3C});
      vq.push_back('{5'h10, 4'h1, 32'hFF,       32'h00, 8'h2E, 8'h3C});
      vq.push_back('{5'h10, 4'h0, 32'h0,        32'h5A, 8'h2E, 8'h3C});
      vq.push_back('{5'h08, 4'h0, 32'h0,        32'h00, 8'h2E, 8'h3C});
      vq.push_back('{5'h0C, 4'h0, 32'h0,        32'h00, 8'h2E, 8'h3C});
      vq.push_back('{5'h00, 4'hF, 32'hFFFFFF0F, 32'h00, 8'h2E, 8'h0F});
      vq.push_back('{5'h00, 4'h0, 32'h0,        32'h0F, 8'h2E, 8'h0F});
      vq.push_back('{5'h07, 4'h0, 32'h0,        32'h2E, 8'h2E, 8'h0F});

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_ready",  {31'h0, mem_ready}, 32'h0);
      check("reset_rdata",  mem_rdata, 32'h0);
      check("reset_irq",    {31'h0, irq}, 32'h0);
      check("reset_uo_en",  {24'h0, gpio_uo_en}, 32'h0);
      check("reset_uo_out", {24'h0, gpio_uo_out}, 32'h0);
      repeat (3) @(posedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         access(vq[i].addr, vq[i].wstrb, vq[i].wdata, vq[i].rdata, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_uo_out", i), {24'h0, gpio_uo_out}, {24'h0, vq[i].out});
         check($sformatf("vec%0d_uo_en", i),  {24'h0, gpio_uo_en},  {24'h0, vq[i].en});
      end

      // Rising edge on pin 0: pending bit appears exactly two edges after sampling.
      access(5'h14, 4'h1, 32'h01, 32'h0, "rise_en_wr");
      @(negedge clk);
      gpio_ui_in = 8'h5B;
      @(posedge clk); #1;
      check("rise_irq_k",  {31'h0, irq}, 32'h0);
      @(posedge clk); #1;
      check("rise_irq_k1", {31'h0, irq}, 32'h0);
      @(posedge clk); #1;
      check("rise_irq_k2", {31'h0, irq}, 32'h1);
      access(5'h1C, 4'h0, 32'h0,  32'h01, "rise_pend_rd");
      access(5'h10, 4'h0, 32'h0,  32'h5B, "rise_in_rd");
      access(5'h1C, 4'h1, 32'h01, 32'h0,  "rise_w1c");
      check("rise_irq_cleared", {31'h0, irq}, 32'h0);

      // Falling edge on pin 7 landing on the same edge as its W1C.
      access(5'h18, 4'h1, 32'h80, 32'h0, "fall_en_wr");
      @(negedge clk);
      gpio_ui_in = 8'hDB;
      repeat (4) @(posedge clk);
      #1;
      check("fall_no_irq_on_rise", {31'h0, irq}, 32'h0);
      @(negedge clk);
      gpio_ui_in = 8'h5B;
      @(posedge clk);
      @(posedge clk);
      access(5'h1C, 4'h1, 32'h80, 32'h0, "fall_w1c_race");
      check("fall_irq_kept", {31'h0, irq}, 32'h1);
      access(5'h1C, 4'h0, 32'h0, 32'h80, "fall_pend_rd");
      access(5'h18, 4'h1, 32'h00, 32'h0, "fall_en_off");
      access(5'h1C, 4'h0, 32'h0, 32'h80, "fall_pend_kept");
      access(5'h1C, 4'h1, 32'h80, 32'h0, "fall_w1c");
      check("fall_irq_cleared", {31'h0, irq}, 32'h0);

      // One-cycle glitch on pin 3 with both edge types enabled.
      @(negedge clk);
      gpio_ui_in = 8'h53;
      repeat (4) @(posedge clk);
      access(5'h14, 4'h1, 32'h08, 32'h0, "glitch_rise_en");
      access(5'h18, 4'h1, 32'h08, 32'h0, "glitch_fall_en");
      check("glitch_irq_before", {31'h0, irq}, 32'h0);
      @(negedge clk);
      gpio_ui_in = 8'h5B;
      @(negedge clk);
      gpio_ui_in = 8'h53;
      repeat (4) @(posedge clk);
      #1;
      check("glitch_irq", {31'h0, irq}, 32'h1);
      check("glitch_no_x", {31'h0, $isunknown({irq, gpio_uo_out, gpio_uo_en, mem_ready, mem_rdata})}, 32'h0);
      access(5'h1C, 4'h0, 32'h0, 32'h08, "glitch_pend_rd");

      // Reset arriving with a write in flight discards the write.
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = 5'h00;
      mem_wstrb = 4'h1;
      mem_wdata = 32'hFF;
      reset     = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ready", {31'h0, mem_ready}, 32'h0);
      check("rst_mid_uo_en", {24'h0, gpio_uo_en}, 32'h0);
      check("rst_mid_uo_out", {24'h0, gpio_uo_out}, 32'h0);
      check("rst_mid_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset     = 1'b0;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      access(5'h00, 4'h0, 32'h0, 32'h00, "rst_mid_reread");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
